// File: rtl/xnor_parity_acc_if.sv
// Word-stream in / frame-parity out handshake bundle
// for xnor_parity_acc.
interface xnor_parity_acc_if #(
  parameter int WIDTH     = 3,
  parameter int MAX_WORDS = 4
);
  localparam int CW = $clog2(MAX_WORDS + 1);

  logic          in_valid;
  logic          in_ready;
  logic [WIDTH-1:0] in_data;
  logic          in_last;
  logic          mode;
  logic          out_valid;
  logic          out_ready;
  logic          out_parity;
  logic [CW-1:0] out_count;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    output mode,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_parity,
    input  out_count
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    input  mode,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_parity,
    output out_count
  );
endinterface

// File: rtl/xnor_parity_acc.sv
// Per-frame XNOR/XOR parity reducer with valid/ready
// on both sides; result held until consumed.
module xnor_parity_acc #(
  parameter int WIDTH     = 3,
  parameter int MAX_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  xnor_parity_acc_if.slave  bus
);
  localparam int CW = $clog2(MAX_WORDS + 1);

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic          acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mode_l_q, mode_l_d;
  logic          first_q, first_d;
  logic          parity_q, parity_d;
  logic [CW-1:0] count_q, count_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;

  logic          accept;
  logic          close;
  logic          mode_eff;
  logic          acc_nxt;
  logic [CW-1:0] cnt_nxt;

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_parity = parity_q;
  assign bus.out_count  = count_q;

  // Next-state: accumulate in ACC, present and wait in HOLD
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    mode_l_d    = mode_l_q;
    first_d     = first_q;
    parity_d    = parity_q;
    count_d     = count_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    accept   = bus.in_valid & in_ready_q;
    acc_nxt  = acc_q ^ (^bus.in_data);
    cnt_nxt  = cnt_q + CW'(1);
    mode_eff = first_q ? bus.mode : mode_l_q;
    close    = accept &
               (bus.in_last |
                (cnt_q == CW'(MAX_WORDS - 1)));

    unique case (state_q)
      ACC: begin
        if (accept) begin
          acc_d = acc_nxt;
          cnt_d = cnt_nxt;
          if (first_q) begin
            mode_l_d = bus.mode;
            first_d  = 1'b0;
          end
        end
        if (close) begin
          parity_d    = acc_nxt ^ mode_eff;
          count_d     = cnt_nxt;
          state_d     = HOLD;
          in_ready_d  = 1'b0;
          out_valid_d = 1'b1;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d     = ACC;
          acc_d       = 1'b0;
          cnt_d       = '0;
          first_d     = 1'b1;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ACC;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACC;
      acc_q       <= 1'b0;
      cnt_q       <= '0;
      mode_l_q    <= 1'b0;
      first_q     <= 1'b1;
      parity_q    <= 1'b0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      mode_l_q    <= mode_l_d;
      first_q     <= first_d;
      parity_q    <= parity_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_xnor_parity_acc.sv
// Directed bench for xnor_parity_acc: a 3-bit and an
// 8-bit instance, both with MAX_WORDS=4.
module tb_xnor_parity_acc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  xnor_parity_acc_if #(.WIDTH(3), .MAX_WORDS(4)) b3 ();
  xnor_parity_acc_if #(.WIDTH(8), .MAX_WORDS(4)) b8 ();

  xnor_parity_acc #(.WIDTH(3), .MAX_WORDS(4)) u3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b3)
  );

  xnor_parity_acc #(.WIDTH(8), .MAX_WORDS(4)) u8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b8)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Offer one word from a negedge; returns at the
  // negedge after it was accepted, with in_valid low.
  task automatic send(input bit w8,
                      input logic [7:0] d,
                      input logic last,
                      input logic md);
    int n = 0;
    if (w8) begin
      b8.in_valid = 1'b1;
      b8.in_data  = d;
      b8.in_last  = last;
      b8.mode     = md;
    end else begin
      b3.in_valid = 1'b1;
      b3.in_data  = d[2:0];
      b3.in_last  = last;
      b3.mode     = md;
    end
    while (!(w8 ? b8.in_ready : b3.in_ready) &&
           n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", 32'(w8 ? b8.in_ready
                             : b3.in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    b8.in_valid = 1'b0;
    b3.in_valid = 1'b0;
  endtask

  // Result must already be valid; check and consume.
  task automatic get(input bit w8,
                     input logic par,
                     input logic [2:0] cnt,
                     input string tag);
    chk({tag, "_valid"}, 32'(w8 ? b8.out_valid
                                : b3.out_valid), 1);
    chk({tag, "_parity"}, 32'(w8 ? b8.out_parity
                                 : b3.out_parity), 32'(par));
    chk({tag, "_count"}, 32'(w8 ? b8.out_count
                                : b3.out_count), 32'(cnt));
    b8.out_ready = w8;
    b3.out_ready = !w8;
    @(negedge clk);
    b8.out_ready = 1'b0;
    b3.out_ready = 1'b0;
    chk({tag, "_drop"}, 32'(w8 ? b8.out_valid
                               : b3.out_valid), 0);
    chk({tag, "_rdy"}, 32'(w8 ? b8.in_ready
                              : b3.in_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] w;
    b3.in_valid = 0; b3.in_data = 0; b3.in_last = 0;
    b3.mode = 0; b3.out_ready = 0;
    b8.in_valid = 0; b8.in_data = 0; b8.in_last = 0;
    b8.mode = 0; b8.out_ready = 0;

    // Reset state
    #12;
    chk("rst_in_ready", 32'(b3.in_ready), 1);
    chk("rst_out_valid", 32'(b3.out_valid), 0);
    chk("rst_parity", 32'(b3.out_parity), 0);
    chk("rst_count", 32'(b3.out_count), 0);
    chk("rst8_out_valid", 32'(b8.out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Truth table, XNOR, single-word frames
    for (int i = 0; i < 8; i++) begin
      w = 3'(i);
      send(0, 8'(w), 1'b1, 1'b1);
      get(0, ~^w, 3'd1, "tt");
    end

    // XOR mode, 8-bit words
    send(1, 8'hFF, 1'b0, 1'b0);
    send(1, 8'h01, 1'b0, 1'b0);
    send(1, 8'h03, 1'b1, 1'b0);
    get(1, 1'b1, 3'd3, "xor8");

    // Force-close at 4 words, then frame 2 from word 5
    repeat (4) send(0, 8'h01, 1'b0, 1'b1);
    get(0, 1'b1, 3'd4, "force1");
    send(0, 8'h01, 1'b0, 1'b1);
    send(0, 8'h01, 1'b0, 1'b1);
    chk("force_open_valid", 32'(b3.out_valid), 0);
    chk("force_open_rdy", 32'(b3.in_ready), 1);
    send(0, 8'h01, 1'b1, 1'b0);
    get(0, 1'b0, 3'd3, "force2");

    // Backpressure with a word offered during HOLD
    send(0, 8'h03, 1'b1, 1'b1);
    b3.in_valid = 1'b1;
    b3.in_data  = 3'b110;
    b3.in_last  = 1'b1;
    b3.mode     = 1'b0;
    repeat (5) begin
      chk("bp_valid", 32'(b3.out_valid), 1);
      chk("bp_parity", 32'(b3.out_parity), 1);
      chk("bp_count", 32'(b3.out_count), 1);
      chk("bp_in_ready", 32'(b3.in_ready), 0);
      @(negedge clk);
    end
    b3.in_valid = 1'b0;
    get(0, 1'b1, 3'd1, "bp");
    send(0, 8'h07, 1'b1, 1'b0);
    get(0, 1'b1, 3'd1, "bp_next");

    // Mode latched from the first word
    send(0, 8'h01, 1'b0, 1'b1);
    send(0, 8'h01, 1'b1, 1'b0);
    get(0, 1'b1, 3'd2, "mode_latch");

    // Reset while holding a result
    send(0, 8'h02, 1'b1, 1'b1);
    chk("hold_pre_rst", 32'(b3.out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("hold_rst_valid", 32'(b3.out_valid), 0);
    chk("hold_rst_count", 32'(b3.out_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset mid-frame discards the partial parity
    send(0, 8'h01, 1'b0, 1'b1);
    send(0, 8'h03, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(b3.out_valid), 0);
    chk("mid_rst_count", 32'(b3.out_count), 0);
    chk("mid_rst_rdy", 32'(b3.in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(0, 8'h04, 1'b1, 1'b0);
    get(0, 1'b1, 3'd1, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
